jt053244_objram_arb: RTL and testbench

JT053244_OBJRAM_ARB -- requirements
Module: jt053244_objram_arb

---
 rtl/jt053244_objram_arb_if.sv | 28 ++
 rtl/jt053244_objram_arb.sv | 144 ++++++++++++++
 tb/tb_jt053244_objram_arb.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jt053244_objram_arb_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jt053244_objram_arb_if : CPU-side request/acknowledge bus to object RAM  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface jt053244_objram_arb_if #(
  parameter int AW = 13
);
  logic          cpu_cs;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [15:0]   cpu_dout;
  logic [1:0]    cpu_dsn;
  logic [15:0]   cpu_din;
  logic          cpu_ok;
  logic [7:0]    cpu_waits;

  modport master (
    output cpu_cs, cpu_we, cpu_addr, cpu_dout, cpu_dsn,
    input  cpu_din, cpu_ok, cpu_waits
  );

  modport slave (
    input  cpu_cs, cpu_we, cpu_addr, cpu_dout, cpu_dsn,
    output cpu_din, cpu_ok, cpu_waits
  );
endinterface
`default_nettype wire

// File: rtl/jt053244_objram_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jt053244_objram_arb : shares object RAM between sprite DMA and the CPU   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module jt053244_objram_arb #(
  parameter int AW = 13
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pxl2_cen,
  jt053244_objram_arb_if.slave    cpu,
  input  logic                    dma_bsy,
  input  logic [AW-1:0]           dma_addr,
  output logic [15:0]             dma_data,
  output logic [AW-1:0]           ram_addr,
  output logic [15:0]             ram_din,
  output logic [1:0]              ram_we,
  input  logic [15:0]             ram_dout
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic [1:0]    dsn_q, dsn_d;
  logic [7:0]    waits_q, waits_d;
  logic [15:0]   din_q, din_d;
  logic          cs_prev_q, cs_prev_d;
  logic          run_q, run_d;
  logic          dma_pend_q, dma_pend_d;
  logic [15:0]   dma_data_q, dma_data_d;
  logic          slot;

  // run_q keeps DMA off the RAM bus while reset is held, so ram_addr reads 0
  assign slot = run_q & pxl2_cen & dma_bsy;

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    data_d     = data_q;
    dsn_d      = dsn_q;
    waits_d    = waits_q;
    din_d      = din_q;
    cs_prev_d  = cpu.cpu_cs;
    run_d      = 1'b1;
    dma_pend_d = slot;
    dma_data_d = dma_pend_q ? ram_dout : dma_data_q;
    ram_addr   = addr_q;
    ram_din    = data_q;
    ram_we     = 2'b00;

    case (state_q)
      ST_IDLE: begin
        // Rising edge only: a request still held across reset is not replayed
        if (cpu.cpu_cs && !cs_prev_q) begin
          we_d    = cpu.cpu_we;
          addr_d  = cpu.cpu_addr;
          data_d  = cpu.cpu_dout;
          dsn_d   = cpu.cpu_dsn;
          waits_d = 8'd0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!cpu.cpu_cs) begin
          waits_d = 8'd0;
          state_d = ST_IDLE;
        end else if (slot) begin
          waits_d = (waits_q == 8'hFF) ? waits_q : waits_q + 8'd1;
        end else if (we_q) begin
          ram_we  = ~dsn_q;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (!cpu.cpu_cs) begin
          waits_d = 8'd0;
          state_d = ST_IDLE;
        end else begin
          din_d   = ram_dout;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!cpu.cpu_cs) begin
          waits_d = 8'd0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (slot) begin
      ram_addr = dma_addr;
      ram_we   = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= 16'd0;
      dsn_q      <= 2'b11;
      waits_q    <= 8'd0;
      din_q      <= 16'd0;
      cs_prev_q  <= 1'b1;
      run_q      <= 1'b0;
      dma_pend_q <= 1'b0;
      dma_data_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      dsn_q      <= dsn_d;
      waits_q    <= waits_d;
      din_q      <= din_d;
      cs_prev_q  <= cs_prev_d;
      run_q      <= run_d;
      dma_pend_q <= dma_pend_d;
      dma_data_q <= dma_data_d;
    end
  end

  assign cpu.cpu_ok    = (state_q == ST_DONE);
  assign cpu.cpu_din   = din_q;
  assign cpu.cpu_waits = waits_q;
  assign dma_data      = dma_data_q;

endmodule
`default_nettype wire

// File: tb/tb_jt053244_objram_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_jt053244_objram_arb : directed vector bench with a behavioural RAM    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_jt053244_objram_arb;
  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          pxl2_cen = 1'b0;
  logic          dma_bsy = 1'b0;
  logic [AW-1:0] dma_addr = '0;
  logic [15:0]   dma_data;
  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_din;
  logic [1:0]    ram_we;
  logic [15:0]   ram_dout;
  logic [15:0]   mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_fail   = 0;

  jt053244_objram_arb_if #(.AW(AW)) cpu_if ();

  jt053244_objram_arb #(.AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pxl2_cen (pxl2_cen),
    .cpu      (cpu_if),
    .dma_bsy  (dma_bsy),
    .dma_addr (dma_addr),
    .dma_data (dma_data),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_we   (ram_we),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  // synchronous RAM, one clock read latency
  always @(posedge clk) begin
    if (ram_we[1]) mem[ram_addr][15:8] <= ram_din[15:8];
    if (ram_we[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
    ram_dout <= mem[ram_addr];
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [15:0]   data;
    logic [1:0]    dsn;
    logic [1:0]    exp_we;
    logic [15:0]   exp_din;
    int            exp_lat;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One complete handshake; cycle 0 is the cycle in which cpu_cs rises
  task automatic cpu_access(input logic we, input logic [AW-1:0] addr, input logic [15:0] data,
                            input logic [1:0] dsn, output int lat, output logic [1:0] we_seen,
                            output int we_cycles, output logic [AW-1:0] we_addr,
                            output logic [15:0] we_din, output logic [15:0] din,
                            output logic [7:0] waits);
    @(posedge clk); #1;
    cpu_if.cpu_cs   = 1'b1;
    cpu_if.cpu_we   = we;
    cpu_if.cpu_addr = addr;
    cpu_if.cpu_dout = data;
    cpu_if.cpu_dsn  = dsn;
    lat = -1; we_seen = 2'b00; we_cycles = 0; we_addr = '0; we_din = 16'd0;
    din = 16'd0; waits = 8'd0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (ram_we != 2'b00) begin
        we_seen = we_seen | ram_we;
        we_cycles++;
        we_addr = ram_addr;
        we_din  = ram_din;
      end
      if (cpu_if.cpu_ok) begin
        lat   = k;
        din   = cpu_if.cpu_din;
        waits = cpu_if.cpu_waits;
        break;
      end
    end
    @(posedge clk); #1;
    cpu_if.cpu_cs = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ok_cleared", {31'd0, cpu_if.cpu_ok}, 32'd0);
    check("waits_cleared", {24'd0, cpu_if.cpu_waits}, 32'd0);
  endtask

  initial begin
    int lat, we_cycles, cnt_we, cnt_ok;
    logic [1:0] we_seen;
    logic [AW-1:0] we_addr;
    logic [15:0] we_din, din;
    logic [7:0] waits;

    vecs[0]  = '{1'b1, 13'h0123, 16'hBEEF, 2'b00, 2'b11, 16'h0000, 2};
    vecs[1]  = '{1'b0, 13'h0123, 16'h0000, 2'b00, 2'b00, 16'hBEEF, 3};
    vecs[2]  = '{1'b1, 13'h0040, 16'hFFFF, 2'b00, 2'b11, 16'h0000, 2};
    vecs[3]  = '{1'b1, 13'h0040, 16'hAAAA, 2'b10, 2'b01, 16'h0000, 2};
    vecs[4]  = '{1'b0, 13'h0040, 16'h0000, 2'b00, 2'b00, 16'hFFAA, 3};
    vecs[5]  = '{1'b1, 13'h0040, 16'h0000, 2'b11, 2'b00, 16'h0000, 2};
    vecs[6]  = '{1'b0, 13'h0040, 16'h0000, 2'b00, 2'b00, 16'hFFAA, 3};
    vecs[7]  = '{1'b1, 13'h1FFF, 16'h1357, 2'b00, 2'b11, 16'h0000, 2};
    vecs[8]  = '{1'b1, 13'h1FFF, 16'h0000, 2'b01, 2'b10, 16'h0000, 2};
    vecs[9]  = '{1'b0, 13'h1FFF, 16'h0000, 2'b00, 2'b00, 16'h0057, 3};
    vecs[10] = '{1'b1, 13'h0010, 16'h1234, 2'b00, 2'b11, 16'h0000, 2};

    cpu_if.cpu_cs = 1'b0; cpu_if.cpu_we = 1'b0; cpu_if.cpu_addr = '0;
    cpu_if.cpu_dout = 16'd0; cpu_if.cpu_dsn = 2'b11;

    // reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_ok", {31'd0, cpu_if.cpu_ok}, 32'd0);
    check("rst_we", {30'd0, ram_we}, 32'd0);
    check("rst_din", {16'd0, cpu_if.cpu_din}, 32'd0);
    check("rst_dma_data", {16'd0, dma_data}, 32'd0);
    check("rst_waits", {24'd0, cpu_if.cpu_waits}, 32'd0);
    check("rst_ram_addr", {19'd0, ram_addr}, 32'd0);
    check("rst_ram_din", {16'd0, ram_din}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // conflict-free vectors
    for (int i = 0; i < 11; i++) begin
      cpu_access(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].dsn,
                 lat, we_seen, we_cycles, we_addr, we_din, din, waits);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_ram_we", i), {30'd0, we_seen}, {30'd0, vecs[i].exp_we});
      check($sformatf("v%0d_we_cycles", i), we_cycles, (vecs[i].exp_we != 2'b00) ? 1 : 0);
      check($sformatf("v%0d_waits", i), {24'd0, waits}, 32'd0);
      if (vecs[i].exp_we != 2'b00) begin
        check($sformatf("v%0d_we_addr", i), {19'd0, we_addr}, {19'd0, vecs[i].addr});
        check($sformatf("v%0d_we_din", i), {16'd0, we_din}, {16'd0, vecs[i].data});
      end
      if (!vecs[i].we)
        check($sformatf("v%0d_cpu_din", i), {16'd0, din}, {16'd0, vecs[i].exp_din});
    end

    // DMA slot read and hold
    @(posedge clk); #1;
    dma_bsy = 1'b1; pxl2_cen = 1'b1; dma_addr = 13'h0010;
    @(negedge clk);
    check("dma_slot_addr", {19'd0, ram_addr}, 32'h0010);
    check("dma_slot_we", {30'd0, ram_we}, 32'd0);
    @(posedge clk); #1;
    pxl2_cen = 1'b0; dma_addr = 13'h0123;
    @(posedge clk);
    @(negedge clk);
    check("dma_data_load", {16'd0, dma_data}, 32'h1234);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("dma_data_hold", {16'd0, dma_data}, 32'h1234);

    // CPU issue collides with a DMA slot
    @(posedge clk); #1;
    cpu_if.cpu_cs = 1'b1; cpu_if.cpu_we = 1'b1; cpu_if.cpu_addr = 13'h0200;
    cpu_if.cpu_dout = 16'h4321; cpu_if.cpu_dsn = 2'b00;
    @(posedge clk); #1;
    pxl2_cen = 1'b1;
    @(negedge clk);
    check("conf_slot_we", {30'd0, ram_we}, 32'd0);
    check("conf_slot_addr", {19'd0, ram_addr}, 32'h0123);
    check("conf_slot_ok", {31'd0, cpu_if.cpu_ok}, 32'd0);
    @(posedge clk); #1;
    pxl2_cen = 1'b0;
    @(negedge clk);
    check("conf_issue_we", {30'd0, ram_we}, 32'h3);
    check("conf_issue_addr", {19'd0, ram_addr}, 32'h0200);
    check("conf_issue_din", {16'd0, ram_din}, 32'h4321);
    check("conf_waits", {24'd0, cpu_if.cpu_waits}, 32'd1);
    @(negedge clk);
    check("conf_ok", {31'd0, cpu_if.cpu_ok}, 32'd1);
    check("conf_dma_data", {16'd0, dma_data}, 32'hBEEF);
    @(posedge clk); #1;
    cpu_if.cpu_cs = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("conf_waits_clr", {24'd0, cpu_if.cpu_waits}, 32'd0);

    // abort during a stall: no write, no ok
    @(posedge clk); #1;
    cpu_if.cpu_cs = 1'b1; cpu_if.cpu_we = 1'b1; cpu_if.cpu_addr = 13'h0300;
    cpu_if.cpu_dout = 16'h7777; cpu_if.cpu_dsn = 2'b00;
    @(posedge clk); #1;
    pxl2_cen = 1'b1;
    @(posedge clk); #1;
    pxl2_cen = 1'b0; cpu_if.cpu_cs = 1'b0;
    cnt_we = 0; cnt_ok = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ram_we != 2'b00) cnt_we++;
      if (cpu_if.cpu_ok) cnt_ok++;
    end
    check("abort_no_we", cnt_we, 0);
    check("abort_no_ok", cnt_ok, 0);
    check("abort_waits", {24'd0, cpu_if.cpu_waits}, 32'd0);

    // dma_bsy low: strobes no longer take slots
    @(posedge clk); #1;
    dma_bsy = 1'b0; pxl2_cen = 1'b1; dma_addr = 13'h0010;
    @(posedge clk); #1;
    pxl2_cen = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("dma_idle_hold", {16'd0, dma_data}, 32'hBEEF);

    // continuous slots saturate cpu_waits
    @(posedge clk); #1;
    dma_bsy = 1'b1; pxl2_cen = 1'b1; dma_addr = 13'h0040;
    cpu_if.cpu_cs = 1'b1; cpu_if.cpu_we = 1'b0; cpu_if.cpu_addr = 13'h0123;
    cnt_we = 0; cnt_ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (ram_we != 2'b00) cnt_we++;
      if (cpu_if.cpu_ok) cnt_ok++;
    end
    check("sat_waits", {24'd0, cpu_if.cpu_waits}, 32'd255);
    check("sat_no_we", cnt_we, 0);
    check("sat_no_ok", cnt_ok, 0);
    @(posedge clk); #1;
    pxl2_cen = 1'b0;
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (cpu_if.cpu_ok) begin lat = k; break; end
    end
    check("sat_latency", lat, 2);
    check("sat_din", {16'd0, cpu_if.cpu_din}, 32'hBEEF);
    @(posedge clk); #1;
    cpu_if.cpu_cs = 1'b0; dma_bsy = 1'b0;
    repeat (2) @(posedge clk);

    // reset while in RD_WAIT
    @(posedge clk); #1;
    cpu_if.cpu_cs = 1'b1; cpu_if.cpu_we = 1'b0; cpu_if.cpu_addr = 13'h0040;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rrst_ok", {31'd0, cpu_if.cpu_ok}, 32'd0);
    check("rrst_we", {30'd0, ram_we}, 32'd0);
    check("rrst_din", {16'd0, cpu_if.cpu_din}, 32'd0);
    check("rrst_dma_data", {16'd0, dma_data}, 32'd0);
    check("rrst_ram_addr", {19'd0, ram_addr}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cnt_we = 0; cnt_ok = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ram_we != 2'b00) cnt_we++;
      if (cpu_if.cpu_ok) cnt_ok++;
    end
    check("rrst_no_we", cnt_we, 0);
    check("rrst_no_ok", cnt_ok, 0);
    @(posedge clk); #1;
    cpu_if.cpu_cs = 1'b0;
    cpu_access(1'b0, 13'h0123, 16'h0000, 2'b00, lat, we_seen, we_cycles, we_addr, we_din, din, waits);
    check("rrst_new_latency", lat, 3);
    check("rrst_new_din", {16'd0, din}, 32'hBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
